// File: rtl/sa_cache_mem_responder.sv
// Memory-side responder for the set-associative cache: one line request at a time,
// fixed-latency completion strobe, line-granular backing store.
module sa_cache_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LINE_W  = 128,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_req_valid,
  output logic              o_mem_req_ready,
  input  logic              i_memRW_in,
  input  logic [ADDR_W-1:0] i_mem_addr_in,
  input  logic [LINE_W-1:0] i_memory_line_in,
  output logic [LINE_W-1:0] o_memory_line_out,
  output logic              o_memory_response_out,
  output logic              o_busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] lineOut_q, lineOut_d;
  logic              storeWe;

  // Backing store survives rst; only its power-up contents are defined as zero.
  logic [LINE_W-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      line_q    <= '0;
      lineOut_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      lineOut_q <= lineOut_d;
    end
  end

  // Gating with rst means a reset in the final WAIT cycle drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && storeWe) begin
      mem_q[addr_q] <= line_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    line_d    = line_q;
    lineOut_d = lineOut_q;
    storeWe   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_mem_req_valid) begin
          rw_d    = i_memRW_in;
          addr_d  = i_mem_addr_in;
          line_d  = i_memory_line_in;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          if (rw_q) begin
            storeWe = 1'b1;
          end else begin
            lineOut_d = mem_q[addr_q];
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_mem_req_ready       = (state_q == S_IDLE);
  assign o_busy                = (state_q != S_IDLE);
  assign o_memory_response_out = (state_q == S_RESP);
  assign o_memory_line_out     = lineOut_q;

endmodule

// File: tb/tb_sa_cache_mem_responder.sv
// Directed bench for sa_cache_mem_responder: a LATENCY=4 instance driven from a vector
// table plus hand sequences, and a LATENCY=1 instance for the short-latency timing.
module tb_sa_cache_mem_responder;

  localparam int ADDR_W = 8;
  localparam int LINE_W = 128;
  localparam int LAT    = 4;
  localparam logic [LINE_W-1:0] LINE_A = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [LINE_W-1:0] LINE_5 = {16{8'hA5}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              valid, rw, ready, resp, busy;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] lineIn, lineOut;
  logic              valid1, rw1, ready1, resp1, busy1;
  logic [ADDR_W-1:0] addr1;
  logic [LINE_W-1:0] lineIn1, lineOut1;

  int checks = 0;
  int errors = 0;

  sa_cache_mem_responder #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_mem_req_valid(valid), .o_mem_req_ready(ready),
    .i_memRW_in(rw), .i_mem_addr_in(addr), .i_memory_line_in(lineIn),
    .o_memory_line_out(lineOut), .o_memory_response_out(resp), .o_busy(busy)
  );

  sa_cache_mem_responder #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_mem_req_valid(valid1), .o_mem_req_ready(ready1),
    .i_memRW_in(rw1), .i_mem_addr_in(addr1), .i_memory_line_in(lineIn1),
    .o_memory_line_out(lineOut1), .o_memory_response_out(resp1), .o_busy(busy1)
  );

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] lineIn;
    logic [LINE_W-1:0] expLine;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the strobe drops.
  task automatic applyStimulus(input logic rwV, input logic [ADDR_W-1:0] a,
                               input logic [LINE_W-1:0] d, output int lat,
                               output logic [LINE_W-1:0] got, output longint tAcc);
    valid  = 1'b1;
    rw     = rwV;
    addr   = a;
    lineIn = d;
    @(posedge clk);
    tAcc = $time;
    lat  = -1;
    got  = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) begin
        valid  = 1'b0;
        rw     = ~rwV;
        addr   = ~a;
        lineIn = '1;
      end
      if (resp) begin
        lat = n;
        got = lineOut;
        break;
      end
    end
    @(negedge clk);
    checkOutput("strobe_width", LINE_W'(resp), '0);
    checkOutput("ready_after", LINE_W'(ready), LINE_W'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int                lat;
    int                strobes;
    logic [LINE_W-1:0] got;
    logic [LINE_W-1:0] modelLast;
    logic [LINE_W-1:0] seen;
    longint            tAcc, tPrev;

    vecs[0] = '{1'b1, 8'h10, LINE_A,       '0};
    vecs[1] = '{1'b0, 8'h10, '0,           LINE_A};
    vecs[2] = '{1'b1, 8'hFF, 128'h1,       '0};
    vecs[3] = '{1'b1, 8'h00, 128'h2,       '0};
    vecs[4] = '{1'b0, 8'hFF, '0,           128'h1};
    vecs[5] = '{1'b0, 8'h00, '0,           128'h2};
    vecs[6] = '{1'b0, 8'h55, '0,           '0};
    vecs[7] = '{1'b1, 8'h55, LINE_5,       '0};
    vecs[8] = '{1'b0, 8'h55, '0,           LINE_5};

    rst = 1'b1;
    valid = 1'b0; rw = 1'b0; addr = '0; lineIn = '0;
    valid1 = 1'b0; rw1 = 1'b0; addr1 = '0; lineIn1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", LINE_W'(ready), LINE_W'(1));
    checkOutput("rst_busy", LINE_W'(busy), '0);
    checkOutput("rst_resp", LINE_W'(resp), '0);
    checkOutput("rst_line", lineOut, '0);
    checkOutput("rst_ready_l1", LINE_W'(ready1), LINE_W'(1));
    rst = 1'b0;

    modelLast = '0;
    tPrev = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].lineIn, lat, got, tAcc);
      checkOutput($sformatf("vec%0d_latency", i), LINE_W'(lat), LINE_W'(LAT));
      if (!vecs[i].rw) modelLast = vecs[i].expLine;
      checkOutput($sformatf("vec%0d_line", i), got, modelLast);
      if (i > 0) checkOutput($sformatf("vec%0d_spacing", i), LINE_W'(tAcc - tPrev),
                             LINE_W'((LAT + 2) * 10));
      tPrev = tAcc;
    end

    // Request pulsed while busy must be dropped, not queued.
    valid = 1'b1; rw = 1'b0; addr = 8'h10; lineIn = '0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1; rw = 1'b1; addr = 8'h20; lineIn = '1;
    strobes = 0;
    seen = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      valid = 1'b0;
      if (resp) begin
        strobes++;
        seen = lineOut;
      end
    end
    checkOutput("busy_ignore_strobes", LINE_W'(strobes), LINE_W'(1));
    checkOutput("busy_ignore_line", seen, LINE_A);
    applyStimulus(1'b0, 8'h20, '0, lat, got, tAcc);
    checkOutput("busy_ignore_read", got, '0);

    // Reset two cycles after accepting a write aborts it.
    valid = 1'b1; rw = 1'b1; addr = 8'h30; lineIn = LINE_5;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midwait_busy", LINE_W'(busy), '0);
    checkOutput("midwait_ready", LINE_W'(ready), LINE_W'(1));
    strobes = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (resp) strobes++;
    end
    checkOutput("midwait_strobes", LINE_W'(strobes), '0);
    applyStimulus(1'b0, 8'h30, '0, lat, got, tAcc);
    checkOutput("midwait_read", got, '0);
    checkOutput("midwait_latency", LINE_W'(lat), LINE_W'(LAT));

    // Reset and request in the same cycle: reset wins.
    rst = 1'b1; valid = 1'b1; rw = 1'b1; addr = 8'h40; lineIn = LINE_A;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    checkOutput("rstwin_busy", LINE_W'(busy), '0);
    strobes = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (resp) strobes++;
    end
    checkOutput("rstwin_strobes", LINE_W'(strobes), '0);
    applyStimulus(1'b0, 8'h40, '0, lat, got, tAcc);
    checkOutput("rstwin_read", got, '0);

    // LATENCY=1 instance: write then read, strobe between edges k+1 and k+2.
    valid1 = 1'b1; rw1 = 1'b1; addr1 = 8'h03; lineIn1 = 128'h77;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0; lineIn1 = '0;
    checkOutput("l1_wr_n0", LINE_W'(resp1), '0);
    @(negedge clk);
    checkOutput("l1_wr_n1", LINE_W'(resp1), LINE_W'(1));
    @(negedge clk);
    checkOutput("l1_wr_n2", LINE_W'(resp1), '0);
    valid1 = 1'b1; rw1 = 1'b0; addr1 = 8'h03;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    checkOutput("l1_rd_n0", LINE_W'(resp1), '0);
    @(negedge clk);
    checkOutput("l1_rd_n1", LINE_W'(resp1), LINE_W'(1));
    checkOutput("l1_rd_line", lineOut1, 128'h77);
    @(negedge clk);
    checkOutput("l1_rd_n2", LINE_W'(resp1), '0);
    checkOutput("l1_ready", LINE_W'(ready1), LINE_W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
